// File: rtl/regfile_wb_arbiter.sv
// Write-port controller for the 32x32 register bank.
// Round-robin arbitration between the ALU writeback (req0) and the load
// writeback (req1), plus a clear sequence that zeroes x1..x(NUM_REGS-1)
// after reset or on request. The bank has no preload, so it starts as
// garbage until this sequence has run.
module regfile_wb_arbiter #(
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 32,
    parameter int NUM_REGS       = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              init_busy,
    output logic              last_grant
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              last_grant_q, last_grant_d;

    logic              grant0_s;
    logic              grant1_s;
    logic              hs0_s;
    logic              hs1_s;

    // Round-robin pick: on contention the requester that did not win last time goes.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (req0_valid && req1_valid) begin
            if (last_grant_q) begin
                grant0_s = 1'b1;
            end else begin
                grant1_s = 1'b1;
            end
        end else if (req0_valid) begin
            grant0_s = 1'b1;
        end else if (req1_valid) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // A clear request steals the cycle, so no requester sees ready alongside it.
    assign req0_ready = (state_q == ST_RUN) && grant0_s && !clear_req;
    assign req1_ready = (state_q == ST_RUN) && grant1_s && !clear_req;
    assign hs0_s      = req0_valid && req0_ready;
    assign hs1_s      = req1_valid && req1_ready;

    // Next-state and next-write computation for the CLEAR/RUN machine.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = clr_cnt_q;
                wr_data_d = ZERO_DATA;
                if (clr_cnt_q == LAST_ADDR) begin
                    clr_cnt_d = ONE_ADDR;
                    state_d   = ST_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + ONE_ADDR;
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = ONE_ADDR;
                end else if (hs0_s) begin
                    // x0 is hardwired zero: accept the request but suppress the write.
                    wr_en_d      = (req0_addr != ZERO_ADDR);
                    wr_addr_d    = req0_addr;
                    wr_data_d    = req0_data;
                    last_grant_d = 1'b0;
                end else if (hs1_s) begin
                    wr_en_d      = (req1_addr != ZERO_ADDR);
                    wr_addr_d    = req1_addr;
                    wr_data_d    = req1_data;
                    last_grant_d = 1'b1;
                end else begin
                    wr_en_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = ONE_ADDR;
            end
        endcase
    end

    // State and registered bank-port flops; rst dominates everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt_q    <= ONE_ADDR;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= ZERO_ADDR;
            wr_data_q    <= ZERO_DATA;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign last_grant = last_grant_q;
    assign init_busy  = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter with a simple bank model.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear_req;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        init_busy;
    logic        last_grant;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] bank [0:31];

    regfile_wb_arbiter #(
        .ADDR_W(5), .DATA_W(32), .NUM_REGS(32), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst(rst), .clear_req(clear_req),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
        .req1_ready(req1_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .init_busy(init_busy), .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    // Raw bank storage: reset fills x1..x31 with garbage; any write is stored, even to x0.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) bank[i] <= (i == 0) ? 32'h0 : 32'hA5A5_A5A5;
        end else if (wr_en) begin
            bank[wr_addr] <= wr_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n0;
        int n1;
        int g;
        logic [4:0] ea;

        rst = 1'b1; clear_req = 1'b0;
        req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 32'h0;
        req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'h0;
        tick();
        tick();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_last_grant", 32'(last_grant), 32'd1);
        chk("rst_init_busy", 32'(init_busy), 32'd1);

        // Clear sequence, with req0 pending the whole time to prove ready stays low.
        rst = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEAD_BEEF;
        for (int i = 1; i <= 31; i++) begin
            #1;
            chk($sformatf("clr_busy_%0d", i), 32'(init_busy), 32'd1);
            chk($sformatf("clr_rdy0_%0d", i), 32'(req0_ready), 32'd0);
            tick();
            chk($sformatf("clr_en_%0d", i), 32'(wr_en), 32'd1);
            chk($sformatf("clr_addr_%0d", i), 32'(wr_addr), 32'(i));
            chk($sformatf("clr_data_%0d", i), wr_data, 32'd0);
        end

        // First RUN cycle: req0 accepted immediately.
        #1;
        chk("run_busy", 32'(init_busy), 32'd0);
        chk("t2_rdy0", 32'(req0_ready), 32'd1);
        chk("t2_rdy1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        chk("t2_wr_en", 32'(wr_en), 32'd1);
        chk("t2_wr_addr", 32'(wr_addr), 32'd5);
        chk("t2_wr_data", wr_data, 32'hDEAD_BEEF);
        chk("t2_last_grant", 32'(last_grant), 32'd0);
        for (int i = 0; i < 32; i++) chk($sformatf("bank_zero_%0d", i), bank[i], 32'd0);
        tick();
        chk("t2_idle_wr_en", 32'(wr_en), 32'd0);
        chk("t2_hold_addr", 32'(wr_addr), 32'd5);
        chk("t2_bank_x5", bank[5], 32'hDEAD_BEEF);

        // Write to x0 via req1: accepted, last_grant moves, no bank write.
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFF_FFFF;
        #1;
        chk("t5_rdy1", 32'(req1_ready), 32'd1);
        chk("t5_rdy0", 32'(req0_ready), 32'd0);
        tick();
        req1_valid = 1'b0;
        chk("t5_wr_en", 32'(wr_en), 32'd0);
        chk("t5_last_grant", 32'(last_grant), 32'd1);
        tick();
        chk("t5_bank_x0", bank[0], 32'd0);

        // Contention with last_grant=1: req0 first, then req1.
        req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h11;
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h22;
        #1;
        chk("t3_rdy0", 32'(req0_ready), 32'd1);
        chk("t3_rdy1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        chk("t3_addr_a", 32'(wr_addr), 32'd3);
        chk("t3_data_a", wr_data, 32'h11);
        #1;
        chk("t3_rdy1_b", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        chk("t3_en_b", 32'(wr_en), 32'd1);
        chk("t3_addr_b", 32'(wr_addr), 32'd4);
        chk("t3_data_b", wr_data, 32'h22);
        chk("t3_last_grant", 32'(last_grant), 32'd1);

        // Four back-to-back requests each: strict alternation, one write per cycle.
        n0 = 0; n1 = 0;
        req0_valid = 1'b1; req0_addr = 5'd8;  req0_data = 32'hA000_0008;
        req1_valid = 1'b1; req1_addr = 5'd16; req1_data = 32'hB000_0010;
        for (int k = 0; k < 8; k++) begin
            g = k % 2;
            ea = (g == 0) ? 5'(8 + n0) : 5'(16 + n1);
            #1;
            chk($sformatf("t4_rdy0_%0d", k), 32'(req0_ready), (g == 0) ? 32'd1 : 32'd0);
            chk($sformatf("t4_rdy1_%0d", k), 32'(req1_ready), (g == 1) ? 32'd1 : 32'd0);
            tick();
            chk($sformatf("t4_en_%0d", k), 32'(wr_en), 32'd1);
            chk($sformatf("t4_addr_%0d", k), 32'(wr_addr), 32'(ea));
            chk($sformatf("t4_data_%0d", k), wr_data,
                ((g == 0) ? 32'hA000_0000 : 32'hB000_0000) | 32'(ea));
            chk($sformatf("t4_lg_%0d", k), 32'(last_grant), 32'(g));
            if (g == 0) begin
                n0++;
                req0_addr = 5'(8 + n0); req0_data = 32'hA000_0000 | 32'(8 + n0);
                if (n0 == 4) req0_valid = 1'b0;
            end else begin
                n1++;
                req1_addr = 5'(16 + n1); req1_data = 32'hB000_0000 | 32'(16 + n1);
                if (n1 == 4) req1_valid = 1'b0;
            end
        end

        // clear_req blocks a pending request, then the full clear runs.
        req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
        clear_req = 1'b1;
        #1;
        chk("t6_rdy0_blocked", 32'(req0_ready), 32'd0);
        tick();
        clear_req = 1'b0;
        chk("t6_no_write", 32'(wr_en), 32'd0);
        chk("t6_busy", 32'(init_busy), 32'd1);
        for (int i = 1; i <= 31; i++) begin
            #1;
            chk($sformatf("t6_rdy0_%0d", i), 32'(req0_ready), 32'd0);
            tick();
            chk($sformatf("t6_addr_%0d", i), 32'(wr_addr), 32'(i));
        end
        #1;
        chk("t6_rdy0_run", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        chk("t6_wr_en", 32'(wr_en), 32'd1);
        chk("t6_wr_addr", 32'(wr_addr), 32'd7);

        // Reset at the 10th clear cycle restarts the sequence from x1.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int i = 1; i <= 9; i++) tick();
        chk("t6r_addr9", 32'(wr_addr), 32'd9);
        rst = 1'b1;
        tick();
        chk("t6r_wr_en", 32'(wr_en), 32'd0);
        chk("t6r_wr_addr", 32'(wr_addr), 32'd0);
        chk("t6r_busy", 32'(init_busy), 32'd1);
        rst = 1'b0;
        tick();
        chk("t6r_restart_en", 32'(wr_en), 32'd1);
        chk("t6r_restart_addr", 32'(wr_addr), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
